// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block and its duty divider.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam int DUTY_W    = 8;
  localparam int DIV_ITERS = 9;
  localparam int DIV_IT_W  = 4;

endpackage

// File: rtl/pwm_capture_if.sv
// PWM capture bus: enable and raw line in, measurement results out.
interface pwm_capture_if #(parameter int CW = 16);
  import pwm_capture_pkg::*;

  logic              ien;
  logic              ipwm;
  logic [CW-1:0]     ohigh;
  logic [CW-1:0]     operiod;
  logic [DUTY_W-1:0] oduty;
  logic              ovalid;
  logic              ostuck;
  logic              olevel;

  modport master (
    output ien, ipwm,
    input  ohigh, operiod, oduty, ovalid, ostuck, olevel
  );

  modport slave (
    input  ien, ipwm,
    output ohigh, operiod, oduty, ovalid, ostuck, olevel
  );

endinterface

// File: rtl/pwm_duty_div.sv
// Sequential restoring divider: floor({high,8'b0}/period), 9 quotient bits, clamped to 8.
module pwm_duty_div
  import pwm_capture_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              istart,
  input  logic              iabort,
  input  logic [CW-1:0]     ihigh,
  input  logic [CW-1:0]     iperiod,
  output logic              obusy,
  output logic              odone,
  output logic [DUTY_W-1:0] oquot
);

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DIV_IT_W-1:0] it_q, it_d;
  logic [CW-1:0]       rem_q, rem_d;
  logic [CW-1:0]       dvs_q, dvs_d;
  logic [DUTY_W:0]     quo_q, quo_d;
  logic [DUTY_W-1:0]   quot_q, quot_d;
  logic [CW:0]         step;

  // One restoring step: shift in a bit, subtract the divisor if it fits.
  // Returns {quotient bit, new remainder}; the remainder always stays below dvs.
  function automatic logic [CW:0] div_step(input logic [CW-1:0] rem,
                                           input logic          bin,
                                           input logic [CW-1:0] dvs);
    logic [CW:0] trial;
    trial = {rem, bin};
    if (trial >= {1'b0, dvs}) div_step = {1'b1, trial[CW-1:0] - dvs};
    else                      div_step = {1'b0, trial[CW-1:0]};
  endfunction

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W:0] q);
    clamp_duty = q[DUTY_W] ? {DUTY_W{1'b1}} : q[DUTY_W-1:0];
  endfunction

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    it_d   = it_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    quot_d = quot_q;
    step   = '0;
    if (iabort) begin
      busy_d = 1'b0;
    end else if (istart) begin
      // high < period, so high>>1 is already below the divisor; the first
      // step brings down high[0] and the remaining eight bring down zeros.
      step   = div_step(ihigh >> 1, ihigh[0], iperiod);
      busy_d = 1'b1;
      it_d   = DIV_IT_W'(1);
      rem_d  = step[CW-1:0];
      dvs_d  = iperiod;
      quo_d  = {{DUTY_W{1'b0}}, step[CW]};
    end else if (busy_q) begin
      step  = div_step(rem_q, 1'b0, dvs_q);
      rem_d = step[CW-1:0];
      quo_d = {quo_q[DUTY_W-1:0], step[CW]};
      it_d  = it_q + DIV_IT_W'(1);
      if (it_q == DIV_IT_W'(DIV_ITERS - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        quot_d = clamp_duty(quo_d);
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      it_q   <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      quot_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      it_q   <= it_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      quot_q <= quot_d;
    end
  end

  // The done cycle still counts as busy so a measurement landing then is dropped.
  assign obusy = busy_q | done_q;
  assign odone = done_q;
  assign oquot = quot_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: synchronizes one PWM line, measures high time and period,
// converts to an 8-bit duty level and flags a stuck line.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CW      = 16,
  parameter int TIMEOUT = 50000
) (
  input logic           iclk,
  input logic           irst,
  pwm_capture_if.slave  bus
);

  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  logic              sync1_q, sync2_q, prev_q;
  logic              rise, fall, timeout_hit;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     hcap_q, hcap_d;
  logic [CW-1:0]     pend_h_q, pend_h_d;
  logic [CW-1:0]     pend_p_q, pend_p_d;
  logic [CW-1:0]     high_q, high_d;
  logic [CW-1:0]     period_q, period_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              seen_q, seen_d;
  logic              valid_q, valid_d;
  logic              stuck_q, stuck_d;
  logic              div_start, div_abort, div_busy, div_done;
  logic [DUTY_W-1:0] div_quot;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge iclk) begin
    if (irst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= bus.ipwm;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise        = sync2_q & ~prev_q;
  assign fall        = ~sync2_q & prev_q;
  assign timeout_hit = ((state_q != ST_IDLE) || seen_q) && (cnt_q == TIMEOUT_C);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcap_d    = hcap_q;
    pend_h_d  = pend_h_q;
    pend_p_d  = pend_p_q;
    high_d    = high_q;
    period_d  = period_q;
    duty_d    = duty_q;
    seen_d    = seen_q;
    valid_d   = 1'b0;
    stuck_d   = stuck_q;
    div_start = 1'b0;
    div_abort = 1'b0;
    if (!bus.ien) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      seen_d    = 1'b0;
      div_abort = 1'b1;
    end else begin
      if (div_done) begin
        high_d   = pend_h_q;
        period_d = pend_p_q;
        duty_d   = div_quot;
        valid_d  = 1'b1;
      end
      if (rise) begin
        state_d = ST_HIGH;
        cnt_d   = CW'(1);
        seen_d  = 1'b1;
        stuck_d = 1'b0;
        // Only a LOW->rise completes a period; a rise seen in HIGH is a
        // glitch and a rise from IDLE has no full period behind it.
        if (state_q == ST_LOW && !div_busy) begin
          div_start = 1'b1;
          pend_h_d  = hcap_q;
          pend_p_d  = cnt_q;
        end
      end else if (timeout_hit) begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        stuck_d   = 1'b1;
        high_d    = '0;
        period_d  = '0;
        duty_d    = sync2_q ? {DUTY_W{1'b1}} : '0;
        valid_d   = 1'b1;
        div_abort = 1'b1;
      end else begin
        if (state_q != ST_IDLE || seen_q) cnt_d = sat_inc(cnt_q);
        // The counter reads H on the falling-edge cycle of an H-cycle pulse.
        if (fall && state_q == ST_HIGH) begin
          hcap_d  = cnt_q;
          state_d = ST_LOW;
        end
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hcap_q   <= '0;
      pend_h_q <= '0;
      pend_p_q <= '0;
      high_q   <= '0;
      period_q <= '0;
      duty_q   <= '0;
      seen_q   <= 1'b0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcap_q   <= hcap_d;
      pend_h_q <= pend_h_d;
      pend_p_q <= pend_p_d;
      high_q   <= high_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      seen_q   <= seen_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  pwm_duty_div #(.CW(CW)) u_div (
    .iclk    (iclk),
    .irst    (irst),
    .istart  (div_start),
    .iabort  (div_abort),
    .ihigh   (hcap_q),
    .iperiod (cnt_q),
    .obusy   (div_busy),
    .odone   (div_done),
    .oquot   (div_quot)
  );

  assign bus.ohigh   = high_q;
  assign bus.operiod = period_q;
  assign bus.oduty   = duty_q;
  assign bus.ovalid  = valid_q;
  assign bus.ostuck  = stuck_q;
  assign bus.olevel  = sync2_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a main instance (long timeout) and a
// stuck-test instance (TIMEOUT=200) share the same PWM line, enable and reset.
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  localparam int CW = 16;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic ien  = 1'b0;
  logic ipwm = 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_capture_if #(.CW(CW)) bus_m ();
  pwm_capture_if #(.CW(CW)) bus_s ();

  assign bus_m.ien  = ien;
  assign bus_m.ipwm = ipwm;
  assign bus_s.ien  = ien;
  assign bus_s.ipwm = ipwm;

  pwm_capture #(.CW(CW), .TIMEOUT(1000)) dut_m (.iclk(clk), .irst(rst), .bus(bus_m));
  pwm_capture #(.CW(CW), .TIMEOUT(200))  dut_s (.iclk(clk), .irst(rst), .bus(bus_s));

  int vcnt_m = 0, vcyc_m = 0, vgap_m = 0, vcnt_s = 0;

  always @(negedge clk) begin
    if (bus_m.ovalid) begin
      vgap_m <= cyc - vcyc_m;
      vcyc_m <= cyc;
      vcnt_m <= vcnt_m + 1;
    end
    if (bus_s.ovalid) vcnt_s <= vcnt_s + 1;
  end

  int nerr = 0, nchk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      ipwm = 1'b1;
      repeat (h) @(negedge clk);
      ipwm = 1'b0;
      repeat (l) @(negedge clk);
    end
  endtask

  task automatic chk_meas(input string tag, input int h, input int p, input int d);
    chk({tag, "_high"},   bus_m.ohigh,   h);
    chk({tag, "_period"}, bus_m.operiod, p);
    chk({tag, "_duty"},   bus_m.oduty,   d);
  endtask

  int base, base_s;

  initial begin
    rst = 1'b1; ien = 1'b1; ipwm = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_high",   bus_m.ohigh,   0);
    chk("rst_period", bus_m.operiod, 0);
    chk("rst_duty",   bus_m.oduty,   0);
    chk("rst_valid",  bus_m.ovalid,  0);
    chk("rst_stuck",  bus_m.ostuck,  0);
    chk("rst_level",  bus_m.olevel,  0);
    rst = 1'b0;
    @(negedge clk);

    // 25/75 square wave
    base = vcnt_m;
    wave(25, 75, 4);
    #1;
    chk("sq_count", vcnt_m - base, 3);
    chk_meas("sq", 25, 100, 64);
    chk("sq_gap",   vgap_m, 100);
    chk("sq_stuck", bus_m.ostuck, 0);

    // extreme duty
    base = vcnt_m;
    wave(1, 254, 3);
    #1;
    chk("min_count", vcnt_m - base, 3);
    chk_meas("min", 1, 255, 1);
    base = vcnt_m;
    wave(254, 1, 3);
    #1;
    chk("max_count", vcnt_m - base, 3);
    chk_meas("max", 254, 255, 254);

    // stuck high on the TIMEOUT=200 instance
    base_s = vcnt_s;
    ipwm = 1'b1;
    repeat (150) @(negedge clk);
    #1;
    chk("stk_early_flag",  bus_s.ostuck, 0);
    chk("stk_early_count", vcnt_s - base_s, 0);
    repeat (100) @(negedge clk);
    #1;
    chk("stk_flag",   bus_s.ostuck,  1);
    chk("stk_level",  bus_s.olevel,  1);
    chk("stk_duty",   bus_s.oduty,   255);
    chk("stk_high",   bus_s.ohigh,   0);
    chk("stk_period", bus_s.operiod, 0);
    chk("stk_count",  vcnt_s - base_s, 1);
    base_s = vcnt_s;
    wave(25, 75, 2);
    #1;
    chk("stk_clear",      bus_s.ostuck, 0);
    chk("stk_idle_count", vcnt_s - base_s, 0);
    base_s = vcnt_s;
    wave(25, 75, 2);
    #1;
    chk("stk_rec_count",  vcnt_s - base_s, 2);
    chk("stk_rec_high",   bus_s.ohigh,   25);
    chk("stk_rec_period", bus_s.operiod, 100);
    chk("stk_rec_duty",   bus_s.oduty,   64);
    chk("stk_rec_flag",   bus_s.ostuck,  0);

    // short period: divider busy drops every other measurement
    base = vcnt_m;
    wave(4, 4, 8);
    #1;
    chk("fast_count", vcnt_m - base, 4);
    chk_meas("fast", 4, 8, 128);
    chk("fast_gap", vgap_m, 16);

    // reset during HIGH
    wave(25, 75, 2);
    ipwm = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mrst_high",   bus_m.ohigh,   0);
    chk("mrst_period", bus_m.operiod, 0);
    chk("mrst_duty",   bus_m.oduty,   0);
    chk("mrst_valid",  bus_m.ovalid,  0);
    chk("mrst_stuck",  bus_s.ostuck,  0);
    chk("mrst_level",  bus_m.olevel,  0);
    rst = 1'b0;
    ipwm = 1'b0;
    base = vcnt_m;
    wave(25, 75, 1);
    #1;
    chk("mrst_first_count", vcnt_m - base, 0);
    wave(25, 75, 1);
    #1;
    chk("mrst_next_count", vcnt_m - base, 1);
    chk_meas("mrst", 25, 100, 64);

    // enable dropped mid-period
    base = vcnt_m;
    ipwm = 1'b1;
    repeat (25) @(negedge clk);
    ipwm = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("en_pre_count", vcnt_m - base, 1);
    base = vcnt_m;
    ien = 1'b0;
    repeat (20) @(negedge clk);
    ipwm = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("en_off_count", vcnt_m - base, 0);
    chk_meas("en_off", 25, 100, 64);
    chk("en_off_level", bus_m.olevel, 1);
    chk("en_off_valid", bus_m.ovalid, 0);
    ien = 1'b1;
    repeat (15) @(negedge clk);
    ipwm = 1'b0;
    repeat (75) @(negedge clk);
    base = vcnt_m;
    wave(25, 75, 1);
    #1;
    chk("en_first_count", vcnt_m - base, 0);
    wave(25, 75, 1);
    #1;
    chk("en_next_count", vcnt_m - base, 1);
    chk_meas("en_next", 25, 100, 64);

    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
PWM receiver/decoder. It is the measurement end of the PWM links driven by the LED PWM generators.
- Samples one asynchronous PWM input and measures the period and high time in iclk cycles.
- Converts the measurement to an 8-bit duty level, the same scale the generators use.
- Flags a stuck line.
- Used for loopback self-test of the LED PWM outputs and for decoding external PWM control pins.

Parameters:
CW, 16, width of the high-time and period counters
TIMEOUT, 50000, cycles without a rising edge before the line is declared stuck (must be below 2^CW-1)

Ports:
iclk  input  1  system clock
irst  input  1  synchronous reset, active-high
ien  input  1  capture enable
ipwm  input  1  asynchronous PWM input
ohigh  output  CW  last measured high time, in cycles
operiod  output  CW  last measured period, in cycles
oduty  output  8  floor(ohigh*256/operiod), clamped to 255
ovalid  output  1  one-cycle pulse when ohigh/operiod/oduty update
ostuck  output  1  line stuck (no rising edge for TIMEOUT cycles)
olevel  output  1  synchronized line level

Behaviour:
- Reset is synchronous, active-high (irst sampled on iclk). All outputs 0, synchronizer flops 0, FSM in IDLE, divider idle.
- Input path:
  - 2-flop synchronizer, then a previous-value register; edges are detected on the synchronized signal.
  - olevel is the synchronized level.
  - Latency from an ipwm transition to the edge-detect pulse is 3 cycles.
- Counting:
  - The period counter loads 1 on the cycle of rising-edge detection and increments every cycle after. It saturates at 2^CW-1.
  - On falling-edge detection, the high count is latched as counter-1.
  - For a clean wave with H high cycles and L low cycles: ohigh=H, operiod=H+L exactly.
- FSM states:
  - IDLE: waiting for the first rising edge. No measurement is taken from a partial period. Rising edge -> HIGH.
  - HIGH: falling edge -> LOW.
  - LOW: rising edge -> complete the measurement, restart the counter, go to HIGH.
  - Rising edge in HIGH (missed falling edge, glitch): discard the measurement, restart the counter, stay in HIGH.
- Completion:
  - The captured high and period go to the divider.
  - The divider is restoring and sequential: 9 quotient iterations on {high,8'b0}/period, one per cycle.
  - ovalid pulses on the 10th cycle after the completing rising edge. ohigh, operiod and oduty update in that same cycle.
  - A quotient of 256 or more is clamped to 255.
  - If the divider is still busy when the next measurement completes (period < 10 cycles), the new measurement is dropped. Counters restart normally.
- Stuck detection:
  - Triggers when the counter reaches TIMEOUT in HIGH or LOW, or TIMEOUT cycles elapse in IDLE after a rising edge has been seen.
  - Response: ostuck=1; ohigh=0, operiod=0; oduty=255 if olevel=1 else 0; one ovalid pulse; FSM -> IDLE.
  - ostuck clears on the next rising-edge detection.
  - The stuck flag has priority over a divider in flight, which is aborted.
- ien=0:
  - FSM forced to IDLE, counters cleared, divider aborted, ovalid=0, no stuck detection.
  - ohigh/operiod/oduty/ostuck hold their values; the synchronizer keeps running.
  - When ien rises, capture waits for a fresh rising edge.
- Reset mid-measurement: everything returns to reset values. The first rising edge after reset produces no ovalid.

Decomposition:
- Shared package/header:
  - FSM state encodings (IDLE, HIGH, LOW).
  - DUTY_W=8.
  - Divider iteration count of 9.
- One sub-module, pwm_duty_div:
  - Sequential restoring divider with istart/obusy/odone handshake and a clamped 8-bit quotient.
  - The same clock and synchronous active-high reset as the parent.

Test Plan:
1. Square wave H=25, L=75, repeated: after the first full period, ovalid every 100 cycles with ohigh=25, operiod=100, oduty=64.
2. H=1, L=254: ohigh=1, operiod=255, oduty=1. H=254, L=1: oduty=254.
3. TIMEOUT=200. Hold ipwm=1 after a rising edge: at counter 200, ostuck=1, olevel=1, oduty=255, ohigh=operiod=0, single ovalid. Resume H=25/L=75: ostuck clears at the rising edge, and the next valid measurement is 25/100/64.
4. Period of 8 cycles (H=4, L=4): first measurement reported (oduty=128). Measurements completing while the divider is busy produce no ovalid; no corrupted values appear.
5. irst pulsed during HIGH of a 25/100 wave: all outputs 0 the next cycle. First ovalid one full period after the first post-reset rising edge.
6. ien dropped mid-period for 30 cycles: no ovalid, outputs hold. After re-enable, the first ovalid comes one full period after the next rising edge.
